// File: rtl/lpc_peripheral.sv
// lpc_peripheral: LPC target decoding I/O (and, with LPC_MEMORY_CYCLE_EN, memory) read/write
// cycles, handing them to a local provider and inserting long-wait SYNCs until it responds.
module lpc_peripheral (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        lframe_i,
    inout  wire  [3:0]  lad_bus,
    inout  wire  [7:0]  lpc_data_io,
    output logic [15:0] lpc_addr_o,
    output logic        lpc_data_wr,
    input  logic        lpc_wr_done,
    input  logic        lpc_data_rd,
    output logic        lpc_rd_done
);
    typedef enum logic [3:0] {
        IDLE, CYCTYPE, ADDR, WDATA, TAR_H1, TAR_H2, SYNC, RDATA, TAR_P1, TAR_P2
    } state_t;

    state_t      r_state;
    logic [11:0] r_addr;
    logic [7:0]  r_data;
    logic [2:0]  r_cnt;
    logic [3:0]  r_lad;
    logic        r_lad_oe, r_write, r_ready;
    logic        w_start, w_cyc_ok, w_prov_ok;

    assign lad_bus     = r_lad_oe ? r_lad : 4'bzzzz;
    assign lpc_data_io = lpc_data_wr ? r_data : 8'bzzzzzzzz;
    assign w_start     = !lframe_i && lad_bus == 4'b0000;
    assign w_prov_ok   = r_write ? lpc_wr_done : lpc_data_rd;
`ifdef LPC_MEMORY_CYCLE_EN
    assign w_cyc_ok = !lad_bus[3];
`else
    assign w_cyc_ok = lad_bus[3:2] == 2'b00;
`endif

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_data      <= '0;
            r_cnt       <= '0;
            r_lad       <= '0;
            r_lad_oe    <= 1'b0;
            r_write     <= 1'b0;
            r_ready     <= 1'b0;
            lpc_addr_o  <= '0;
            lpc_data_wr <= 1'b0;
            lpc_rd_done <= 1'b0;
        end else begin
            lpc_rd_done <= 1'b0;
            // LFRAME# low outside IDLE aborts, and that same nibble may already be a new START
            if (r_state != IDLE && !lframe_i) begin
                r_state     <= w_start ? CYCTYPE : IDLE;
                r_lad_oe    <= 1'b0;
                lpc_data_wr <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: r_state <= w_start ? CYCTYPE : IDLE;
                    CYCTYPE: begin
                        r_write <= lad_bus[1];
                        r_cnt   <= lad_bus[2] ? 3'd7 : 3'd3;
                        r_state <= w_cyc_ok ? ADDR : IDLE;
                    end
                    ADDR: begin
                        r_addr <= {r_addr[7:0], lad_bus};
                        r_cnt  <= r_cnt - 3'd1;
                        if (r_cnt == 3'd0) begin
                            lpc_addr_o <= {r_addr, lad_bus};
                            r_cnt      <= 3'd1;
                            r_state    <= r_write ? WDATA : TAR_H1;
                        end
                    end
                    WDATA: begin
                        r_data <= {lad_bus, r_data[7:4]};
                        r_cnt  <= r_cnt - 3'd1;
                        if (r_cnt == 3'd0) begin
                            lpc_data_wr <= 1'b1;
                            r_state     <= TAR_H1;
                        end
                    end
                    TAR_H1: r_state <= TAR_H2;
                    TAR_H2, SYNC: begin
                        // r_ready marks that the nibble now on the bus is the 0000 ready SYNC
                        if (r_state == SYNC && r_ready) begin
                            r_state <= r_write ? TAR_P1 : RDATA;
                            r_lad   <= r_write ? 4'b1111 : r_data[3:0];
                            r_cnt   <= 3'd1;
                        end else begin
                            r_state     <= SYNC;
                            r_lad_oe    <= 1'b1;
                            r_ready     <= w_prov_ok;
                            r_lad       <= w_prov_ok ? 4'b0000 : 4'b0110;
                            lpc_data_wr <= lpc_data_wr && !w_prov_ok;
                            lpc_rd_done <= w_prov_ok && !r_write;
                            if (w_prov_ok && !r_write) r_data <= lpc_data_io;
                        end
                    end
                    RDATA: begin
                        r_cnt <= r_cnt - 3'd1;
                        r_lad <= r_cnt == 3'd1 ? r_data[7:4] : 4'b1111;
                        if (r_cnt == 3'd0) r_state <= TAR_P1;
                    end
                    TAR_P1: begin
                        r_lad_oe <= 1'b0;
                        r_state  <= TAR_P2;
                    end
                    TAR_P2:  r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lpc_peripheral.sv
// tb_lpc_peripheral: table-driven and randomized LPC host/provider bench; expected bus traces
// are derived from the protocol rules (nibble counts, SYNC length), honouring LPC_MEMORY_CYCLE_EN.
module tb_lpc_peripheral;
`ifdef LPC_MEMORY_CYCLE_EN
    localparam bit MEM_EN = 1'b1;
`else
    localparam bit MEM_EN = 1'b0;
`endif

    logic        clk_i = 1'b0, nrst_i = 1'b0, lframe_i = 1'b1;
    logic        lpc_wr_done = 1'b0, lpc_data_rd = 1'b0;
    logic [15:0] lpc_addr_o;
    logic        lpc_data_wr, lpc_rd_done;
    wire  [3:0]  lad_bus;
    wire  [7:0]  lpc_data_io;
    logic        host_oe = 1'b0, prov_oe = 1'b0;
    logic [3:0]  host_lad = 4'h0;
    logic [7:0]  prov_dat = 8'h00;

    assign lad_bus     = host_oe ? host_lad : 4'bzzzz;
    assign lpc_data_io = prov_oe ? prov_dat : 8'bzzzzzzzz;
    wire lad_z = (lad_bus === 4'bzzzz);
    wire dio_z = (lpc_data_io === 8'bzzzzzzzz);

    lpc_peripheral dut (
        .clk_i(clk_i), .nrst_i(nrst_i), .lframe_i(lframe_i), .lad_bus(lad_bus),
        .lpc_data_io(lpc_data_io), .lpc_addr_o(lpc_addr_o), .lpc_data_wr(lpc_data_wr),
        .lpc_wr_done(lpc_wr_done), .lpc_data_rd(lpc_data_rd), .lpc_rd_done(lpc_rd_done)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0, n_tot = 0;

    typedef struct {
        bit          mem;
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  wd;
        logic [7:0]  rd;
        int          dly;
        int          nst;
        logic [15:0] ea;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    endtask

    // 5'h10 stands for a released (Z) bus
    function automatic logic [4:0] lad_code();
        return lad_z ? 5'h10 : {1'b0, lad_bus};
    endfunction

    task automatic host_cyc(input logic lf, input logic oe, input logic [3:0] nib);
        @(negedge clk_i);
        lframe_i = lf;
        host_oe  = oe;
        host_lad = nib;
        #1;
    endtask

    task automatic frame(input bit mem, input bit wr, input logic [31:0] addr, input logic [7:0] wd,
                         input logic [7:0] rd, input int dly, input int nst);
        logic [3:0]  host[$];
        logic [4:0]  xl[$];
        logic [15:0] prev;
        bit          ok, xw;
        int          hl, t2;
        prev = lpc_addr_o;
        ok   = !mem || MEM_EN;
        repeat (nst) host.push_back(4'h0);
        host.push_back({1'b0, mem, wr, 1'b0});
        for (int i = (mem ? 7 : 3); i >= 0; i--) host.push_back(addr[4*i +: 4]);
        if (wr) begin
            host.push_back(wd[3:0]);
            host.push_back(wd[7:4]);
        end
        hl = host.size();
        t2 = hl + 2;
        xl.push_back(5'h10);
        xl.push_back(5'h10);
        if (ok) begin
            repeat (dly) xl.push_back(5'h06);
            xl.push_back(5'h00);
            if (!wr) begin
                xl.push_back({1'b0, rd[3:0]});
                xl.push_back({1'b0, rd[7:4]});
            end
            xl.push_back(5'h0F);
        end else repeat (dly + 1) xl.push_back(5'h10);
        xl.push_back(5'h10);
        xl.push_back(5'h10);
        for (int c = 1; c <= hl + xl.size(); c++) begin
            @(negedge clk_i);
            lframe_i = !(c <= nst);
            host_oe  = c <= hl;
            if (c <= hl) host_lad = host[c-1];
            lpc_wr_done = ok && wr && c == t2 + dly;
            lpc_data_rd = ok && !wr && c == t2 + dly;
            prov_oe  = lpc_data_rd;
            prov_dat = rd;
            #1;
            xw = ok && wr && c > hl && c <= t2 + dly;
            chk("data_wr", 32'(lpc_data_wr), 32'(xw));
            chk("rd_done", 32'(lpc_rd_done), 32'(ok && !wr && c == t2 + dly + 1));
            if (c > hl) chk("lad", 32'(lad_code()), 32'(xl[c-hl-1]));
            if (xw) begin
                chk("wr_addr", 32'(lpc_addr_o), 32'(addr[15:0]));
                chk("wr_data", 32'(lpc_data_io), 32'(wd));
            end
        end
        host_oe     = 1'b0;
        prov_oe     = 1'b0;
        lpc_wr_done = 1'b0;
        lpc_data_rd = 1'b0;
        lframe_i    = 1'b1;
        chk("addr_hold", 32'(lpc_addr_o), 32'(ok ? addr[15:0] : prev));
    endtask

    initial begin
        vec_t tbl[6];
        tbl[0] = '{1'b0, 1'b1, 32'h0000_F0F0, 8'h5A, 8'h00, 0,  1, 16'hF0F0};
        tbl[1] = '{1'b0, 1'b1, 32'h0000_9696, 8'hA5, 8'h00, 10, 1, 16'h9696};
        tbl[2] = '{1'b0, 1'b0, 32'h0000_0001, 8'h00, 8'h3C, 2,  1, 16'h0001};
        tbl[3] = '{1'b0, 1'b1, 32'h0000_0000, 8'hFF, 8'h00, 1,  3, 16'h0000};
        tbl[4] = '{1'b0, 1'b0, 32'h0000_1234, 8'h00, 8'hA5, 0,  1, 16'h1234};
        tbl[5] = '{1'b1, 1'b1, 32'h1234_ABCD, 8'h77, 8'h00, 1,  1, MEM_EN ? 16'hABCD : 16'h1234};

        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_addr", 32'(lpc_addr_o), 32'h0);
        chk("rst_data_wr", 32'(lpc_data_wr), 32'h0);
        chk("rst_rd_done", 32'(lpc_rd_done), 32'h0);
        chk("rst_lad", 32'(lad_code()), 32'h10);
        chk("rst_dio_z", 32'(dio_z), 32'h1);
        nrst_i = 1'b1;

        foreach (tbl[i]) begin
            frame(tbl[i].mem, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].rd, tbl[i].dly, tbl[i].nst);
            chk("tbl_addr", 32'(lpc_addr_o), 32'(tbl[i].ea));
        end

        for (int i = 0; i <= 128; i++) begin
            frame(1'b1, 1'b1, 32'(i), i[7:0], 8'h00, 0, 1);
            frame(1'b1, 1'b0, 32'(i), 8'h00, 8'hBB + i[7:0], i % 3, 1);
        end

        // abort in the middle of the address phase, then a clean write
        host_cyc(1'b0, 1'b1, 4'h0);
        host_cyc(1'b1, 1'b1, 4'b0010);
        host_cyc(1'b1, 1'b1, 4'hC);
        host_cyc(1'b1, 1'b1, 4'h3);
        chk("abort_data_wr", 32'(lpc_data_wr), 32'h0);
        frame(1'b0, 1'b1, 32'h0000_C3C3, 8'h81, 8'h00, 1, 1);
        chk("abort_addr", 32'(lpc_addr_o), 32'hC3C3);

        // reset while the provider keeps the SYNC in long wait
        host_cyc(1'b0, 1'b1, 4'h0);
        host_cyc(1'b1, 1'b1, 4'b0010);
        host_cyc(1'b1, 1'b1, 4'h1);
        host_cyc(1'b1, 1'b1, 4'h2);
        host_cyc(1'b1, 1'b1, 4'h3);
        host_cyc(1'b1, 1'b1, 4'h4);
        host_cyc(1'b1, 1'b1, 4'hC);
        host_cyc(1'b1, 1'b1, 4'h3);
        host_cyc(1'b1, 1'b0, 4'h0);
        host_cyc(1'b1, 1'b0, 4'h0);
        chk("pre_rst_data_wr", 32'(lpc_data_wr), 32'h1);
        repeat (3) begin
            host_cyc(1'b1, 1'b0, 4'h0);
            chk("wait_lad", 32'(lad_code()), 32'h06);
        end
        #2 nrst_i = 1'b0;
        #1;
        chk("mid_rst_data_wr", 32'(lpc_data_wr), 32'h0);
        chk("mid_rst_lad", 32'(lad_code()), 32'h10);
        chk("mid_rst_addr", 32'(lpc_addr_o), 32'h0);
        chk("mid_rst_dio_z", 32'(dio_z), 32'h1);
        @(negedge clk_i);
        nrst_i = 1'b1;
        frame(1'b0, 1'b0, 32'h0000_BEEF, 8'h00, 8'h96, 1, 1);

        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) begin
                host_cyc(1'b1, 1'b0, 4'h0);
                chk("idle_lad", 32'(lad_code()), 32'h10);
            end
            frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 8'($urandom),
                  8'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(1, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
